fcmp_unit: RTL and testbench

Pipelined, handshaked floating-point compare/select unit for the FPU issue path. It accepts single-precision operand pairs with an opcode and tag from the dispatcher over valid/ready. It returns a 32-bit result (boolean compare or selected operand) two cycles later, under downstream backpressure. It is the responder end of the FPU request/response protocol for compare-class ops, replacing bare combinational compares.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fcmp_core.sv | 20 ++
 rtl/fcmp_unit.sv | 87 ++++++++
 tb/tb_fcmp_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU op codes, canonical NaN and the float order-key function
package fpu_pkg;
  localparam logic [2:0] FOP_FEQ  = 3'd0;
  localparam logic [2:0] FOP_FLT  = 3'd1;
  localparam logic [2:0] FOP_FLE  = 3'd2;
  localparam logic [2:0] FOP_FMIN = 3'd3;
  localparam logic [2:0] FOP_FMAX = 3'd4;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  // Maps a single-precision value onto an unsigned key with the same ordering; both zeros share one key
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return ~|x[30:0] ? 32'h8000_0000 : x[31] ? ~x : x ^ 32'h8000_0000;
  endfunction
endpackage

// File: rtl/fcmp_core.sv
// fcmp_core: combinational key compare (lt/eq) with per-operand NaN flags under FCMP_NAN_EN
module fcmp_core (
  input  logic [31:0] k1,
  input  logic [31:0] k2,
`ifdef FCMP_NAN_EN
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        n1,
  output logic        n2,
`endif
  output logic        lt,
  output logic        eq
);
  assign lt = k1 < k2;
  assign eq = k1 == k2;
`ifdef FCMP_NAN_EN
  assign n1 = &x1[30:23] & |x1[22:0];
  assign n2 = &x2[30:23] & |x2[22:0];
`endif
endmodule

// File: rtl/fcmp_unit.sv
// fcmp_unit: two-stage valid/ready FP compare/select unit; define FCMP_NAN_EN for NaN-aware results
module fcmp_unit
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
);
  logic             s1_v, s2_v, s1_en, s2_en;
  logic [31:0]      s1_k1, s1_k2, s1_x1, s1_x2;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             lt, eq, le, anyn;
  logic [31:0]      min_y, max_y, res;
  assign s2_en     = ~s2_v | out_ready;
  assign s1_en     = ~s1_v | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_v;
  assign le        = lt | eq;
`ifdef FCMP_NAN_EN
  logic n1, n2;
  fcmp_core u_core (.k1(s1_k1), .k2(s1_k2), .x1(s1_x1), .x2(s1_x2), .n1(n1), .n2(n2), .lt(lt), .eq(eq));
  assign anyn  = n1 | n2;
  assign min_y = n1 & n2 ? CANON_NAN : n1 ? s1_x2 : n2 ? s1_x1 : le ? s1_x1 : s1_x2;
  assign max_y = n1 & n2 ? CANON_NAN : n1 ? s1_x2 : n2 ? s1_x1 : lt ? s1_x2 : s1_x1;
`else
  fcmp_core u_core (.k1(s1_k1), .k2(s1_k2), .lt(lt), .eq(eq));
  assign anyn  = 1'b0;
  assign min_y = le ? s1_x1 : s1_x2;
  assign max_y = lt ? s1_x2 : s1_x1;
`endif
  // Select the result for the op held in stage 1; reserved ops yield zero
  always_comb begin
    res = s1_op == FOP_FEQ  ? {31'b0, eq & ~anyn} :
          s1_op == FOP_FLT  ? {31'b0, lt & ~anyn} :
          s1_op == FOP_FLE  ? {31'b0, le & ~anyn} :
          s1_op == FOP_FMIN ? min_y :
          s1_op == FOP_FMAX ? max_y : 32'b0;
  end
  // Stage 1: capture keys, raw operands, op and tag of an accepted request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v   <= 1'b0;
      s1_k1  <= '0;
      s1_k2  <= '0;
      s1_x1  <= '0;
      s1_x2  <= '0;
      s1_op  <= '0;
      s1_tag <= '0;
    end else if (s1_en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_k1  <= fkey(in_x1);
        s1_k2  <= fkey(in_x2);
        s1_x1  <= in_x1;
        s1_x2  <= in_x2;
        s1_op  <= in_op;
        s1_tag <= in_tag;
      end
    end
  end
  // Stage 2: register the result; held untouched while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_v    <= 1'b0;
      out_y   <= '0;
      out_tag <= '0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_y   <= res;
        out_tag <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_fcmp_unit.sv
// tb_fcmp_unit: directed checks plus a real-valued reference model and scoreboard for fcmp_unit
module tb_fcmp_unit;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_x1 = '0;
  logic [31:0] in_x2 = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
  int checks = 0;
  int fails = 0;
  int popped = 0;
  logic [31:0] exp_y[$];
  logic [3:0]  exp_t[$];
  logic        stall = 1'b0;
  logic [31:0] hy;
  logic [3:0]  ht;

  fcmp_unit #(.TAG_W(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic isnan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction

  function automatic real fval(input logic [31:0] x);
    int  e;
    real m;
    e = int'(x[30:23]);
    if (e == 255) m = 1.0e300;
    else if (e == 0) m = real'(x[22:0]) * 2.0 ** (-149);
    else m = (1.0 + real'(x[22:0]) / 8388608.0) * 2.0 ** (e - 127);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    logic na, nb, any;
    ra = fval(a);
    rb = fval(b);
`ifdef FCMP_NAN_EN
    na = isnan(a);
    nb = isnan(b);
`else
    na = 1'b0;
    nb = 1'b0;
`endif
    any = na | nb;
    case (op)
      3'd0: return {31'b0, !any && ra == rb};
      3'd1: return {31'b0, !any && ra < rb};
      3'd2: return {31'b0, !any && ra <= rb};
      3'd3: return na && nb ? 32'h7FC0_0000 : na ? b : nb ? a : (ra <= rb ? a : b);
      3'd4: return na && nb ? 32'h7FC0_0000 : na ? b : nb ? a : (ra >= rb ? a : b);
      default: return 32'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      exp_y.delete();
      exp_t.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_y", out_y, hy);
        chk("hold_tag", {28'b0, out_tag}, {28'b0, ht});
      end
      chk("in_ready", {31'b0, in_ready}, {31'b0, !(exp_y.size() == 2 && !out_ready)});
      if (out_valid && out_ready) begin
        if (exp_y.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          chk("sb_y", out_y, exp_y.pop_front());
          chk("sb_tag", {28'b0, out_tag}, {28'b0, exp_t.pop_front()});
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        exp_y.push_back(model(in_op, in_x1, in_x2));
        exp_t.push_back(in_tag);
      end
      stall = out_valid && !out_ready;
      hy = out_y;
      ht = out_tag;
    end
  end

  task automatic send(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, input logic [31:0] ey);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_op = op;
    in_x1 = a;
    in_x2 = b;
    in_tag = t;
    out_ready = 1'b1;
    chk({nm, "_rdy"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, "_early"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({nm, "_y"}, out_y, ey);
    chk({nm, "_tag"}, {28'b0, out_tag}, {28'b0, t});
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  s_op[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd1};
  logic [31:0] s_a[8]  = '{32'h3F800000, 32'h40400000, 32'hBF800000, 32'h7F800000,
                           32'hFF800000, 32'h3F800000, 32'h00000000, 32'h80000001};
  logic [31:0] s_b[8]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h42C80000,
                           32'h00000001, 32'h40000000, 32'h80000000, 32'h00000000};
  logic        pat[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_y", out_y, 32'd0);
    chk("rst_tag", {28'b0, out_tag}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    send("fle", 3'd2, 32'h3F800000, 32'h40000000, 4'd5, 32'd1);
    send("feq_zero", 3'd0, 32'h80000000, 32'h00000000, 4'd1, 32'd1);
    send("fmin_zero", 3'd3, 32'h80000000, 32'h00000000, 4'd2, 32'h80000000);
    send("fmax_neg", 3'd4, 32'hC0000000, 32'hBF800000, 4'd3, 32'hBF800000);
    send("flt_neg", 3'd1, 32'hC0000000, 32'hBF800000, 4'd4, 32'd1);
    send("resv", 3'd7, 32'h3F800000, 32'h40000000, 4'd9, 32'd0);
`ifdef FCMP_NAN_EN
    send("nan_fle", 3'd2, 32'h7FC00001, 32'h3F800000, 4'd6, 32'd0);
    send("nan_fmin", 3'd3, 32'h7FC00001, 32'h3F800000, 4'd7, 32'h3F800000);
    send("nan_fmax2", 3'd4, 32'h7FC00001, 32'hFFC00000, 4'd8, 32'h7FC00000);
    send("nan_feq", 3'd0, 32'h7FC00001, 32'h7FC00001, 4'd10, 32'd0);
`endif
    popped = 0;
    begin
      int i = 0;
      int cyc = 0;
      logic acc;
      while (i < 8 && cyc < 200) begin
        in_valid = 1'b1;
        in_op = s_op[i];
        in_x1 = s_a[i];
        in_x2 = s_b[i];
        in_tag = 4'(i + 3);
        out_ready = pat[cyc % 4];
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) i++;
      end
      in_valid = 1'b0;
      while (popped < 8 && cyc < 300) begin
        out_ready = pat[cyc % 4];
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("stream_count", popped, 32'd8);
    end
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_op = 3'd0;
    in_x1 = 32'h3F800000;
    in_x2 = 32'h3F800000;
    in_tag = 4'd11;
    @(posedge clk);
    #1;
    in_tag = 4'd12;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("prerst_valid", {31'b0, out_valid}, 32'd1);
    chk("prerst_ready", {31'b0, in_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_y", out_y, 32'd0);
    chk("async_rst_tag", {28'b0, out_tag}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    send("post_rst", 3'd1, 32'h3F800000, 32'h40000000, 4'd13, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
